fft_mag_frame_buf: RTL and testbench

Sits directly downstream of the fft wrapper and consumes its unscaled output AXI4-Stream (xk data, tlast, tuser index), with no backpressure.
Computes an approximate magnitude per bin through a 3-stage pipeline and writes it into a ping-pong bin RAM.
Publishes each complete frame to the display/readout side through a 1-cycle-latency read port and a frame-done pulse.
Malformed frames are dropped and flagged.

---
 rtl/fft_mag_pkg.sv | 38 +++
 rtl/fft_mag_frame_buf_if.sv | 12 +
 rtl/fft_mag_approx.sv | 63 ++++++
 rtl/fft_mag_frame_buf.sv | 174 +++++++++++++++++
 tb/tb_fft_mag_frame_buf.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_mag_pkg.sv
// Shared constants, FSM state and pipeline tag for the FFT magnitude frame buffer.
package fft_mag_pkg;

  localparam int unsigned LOGS_FFT_LEN = 11;
  localparam int unsigned DATA_WIDTH   = 28;
  localparam int unsigned LANE_WIDTH   = 32;
  localparam int unsigned MAG_WIDTH    = 16;
  localparam int unsigned MAG_SHIFT    = 0;
  localparam int unsigned TUSER_WIDTH  = 16;
  localparam int unsigned TDATA_WIDTH  = 2 * LANE_WIDTH;
  localparam int unsigned ABS_WIDTH    = DATA_WIDTH - 1;
  localparam int unsigned SUM_WIDTH    = DATA_WIDTH + 1;

  localparam int unsigned N_BINS  = 2 ** LOGS_FFT_LEN;
  localparam int unsigned MAG_MAX = 2 ** MAG_WIDTH - 1;

  localparam int unsigned RE_LSB = 0;
  localparam int unsigned IM_LSB = LANE_WIDTH;

  typedef struct packed {
    logic                    valid;
    logic                    last;
    logic [LOGS_FFT_LEN-1:0] idx;
  } mag_tag_t;

  typedef enum logic {
    ST_ACCUM   = 1'b0,
    ST_DISCARD = 1'b1
  } frame_state_t;

  // |x| of a signed component; the most negative code clamps to the largest positive one
  function automatic logic [ABS_WIDTH-1:0] abs_sat(input logic [DATA_WIDTH-1:0] x);
    if (!x[DATA_WIDTH-1]) return ABS_WIDTH'(x);
    if (x[ABS_WIDTH-1:0] == '0) return '1;
    return ABS_WIDTH'(-x);
  endfunction

endpackage

// File: rtl/fft_mag_frame_buf_if.sv
// Unscaled FFT output AXI4-Stream (no backpressure) feeding the magnitude frame buffer.
interface fft_mag_frame_buf_if;
  import fft_mag_pkg::*;

  logic                   tvalid;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic [TUSER_WIDTH-1:0] tuser;

  modport master (output tvalid, tdata, tlast, tuser);
  modport slave  (input  tvalid, tdata, tlast, tuser);
endinterface

// File: rtl/fft_mag_approx.sv
// Abs / sort / alpha-max-beta-min magnitude pipeline; stage 3 is combinational into the RAM write.
module fft_mag_approx
  import fft_mag_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   srstn,
  input  logic                   i_aclken,
  input  logic [TDATA_WIDTH-1:0] i_tdata,
  input  mag_tag_t               i_tag,
  output logic [MAG_WIDTH-1:0]   o_mag_c,
  output mag_tag_t               o_tag_c
);

  logic [DATA_WIDTH-1:0] w_re;
  logic [DATA_WIDTH-1:0] w_im;
  logic [ABS_WIDTH-1:0]  r_abs_re;
  logic [ABS_WIDTH-1:0]  r_abs_im;
  logic [ABS_WIDTH-1:0]  r_mx;
  logic [ABS_WIDTH-1:0]  r_mn;
  mag_tag_t              r_tag1;
  mag_tag_t              r_tag2;
  logic [SUM_WIDTH-1:0]  w_sum;
  logic [SUM_WIDTH-1:0]  w_shifted;
  logic                  w_unused_lanes;

  assign w_re = i_tdata[RE_LSB +: DATA_WIDTH];
  assign w_im = i_tdata[IM_LSB +: DATA_WIDTH];
  assign w_unused_lanes = ^{i_tdata[RE_LSB+DATA_WIDTH +: LANE_WIDTH-DATA_WIDTH],
                            i_tdata[IM_LSB+DATA_WIDTH +: LANE_WIDTH-DATA_WIDTH]};

  // Stage 1 absolute value, stage 2 max/min sort
  always_ff @(posedge i_clk or negedge srstn) begin
    if (!srstn) begin
      r_tag1   <= '0;
      r_tag2   <= '0;
      r_abs_re <= '0;
      r_abs_im <= '0;
      r_mx     <= '0;
      r_mn     <= '0;
    end else if (i_aclken) begin
      r_tag1   <= i_tag;
      r_abs_re <= abs_sat(w_re);
      r_abs_im <= abs_sat(w_im);
      r_tag2   <= r_tag1;
      if (r_abs_re >= r_abs_im) begin
        r_mx <= r_abs_re;
        r_mn <= r_abs_im;
      end else begin
        r_mx <= r_abs_im;
        r_mn <= r_abs_re;
      end
    end
  end

  // Stage 3: mx + mn/4 + mn/8 has headroom in SUM_WIDTH, then shift and clamp
  always_comb begin
    w_sum     = SUM_WIDTH'(r_mx) + SUM_WIDTH'(r_mn >> 2) + SUM_WIDTH'(r_mn >> 3);
    w_shifted = w_sum >> MAG_SHIFT;
    o_mag_c   = (w_shifted > SUM_WIDTH'(MAG_MAX)) ? MAG_WIDTH'(MAG_MAX) : MAG_WIDTH'(w_shifted);
    o_tag_c   = r_tag2;
  end

endmodule

// File: rtl/fft_mag_frame_buf.sv
// Ping-pong magnitude frame buffer with frame close / drop / length-error control.
// Optional FFT_MAG_PEAK_EN adds per-frame peak bin tracking (o_peak_idx, o_peak_mag).
module fft_mag_frame_buf
  import fft_mag_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    srstn,
  input  logic                    i_aclken,
  fft_mag_frame_buf_if.slave      i_axi4s_data,
  input  logic                    i_rd_busy,
  input  logic [LOGS_FFT_LEN-1:0] i_rd_addr,
  output logic [MAG_WIDTH-1:0]    o_rd_data,
  output logic                    o_frame_done,
  output logic                    o_frame_drop,
  output logic                    o_len_err,
  output logic                    o_rd_bank
`ifdef FFT_MAG_PEAK_EN
  ,
  output logic [LOGS_FFT_LEN-1:0] o_peak_idx,
  output logic [MAG_WIDTH-1:0]    o_peak_mag
`endif
);

  localparam logic [LOGS_FFT_LEN-1:0] CNT_LAST = LOGS_FFT_LEN'(N_BINS - 1);

  mag_tag_t                w_in_tag;
  mag_tag_t                w_tag;
  logic [MAG_WIDTH-1:0]    w_mag;
  logic                    w_unused_tuser;

  frame_state_t            r_state;
  frame_state_t            w_state_nxt;
  logic [LOGS_FFT_LEN-1:0] r_cnt;
  logic [LOGS_FFT_LEN-1:0] w_cnt_nxt;
  logic                    w_wr_en;
  logic                    w_swap;
  logic                    w_drop;
  logic                    w_err;

  logic                    r_done;
  logic                    r_drop;
  logic                    r_err;
  logic                    r_pub_bank;
  logic                    r_wr_bank;
  logic                    r_rd_bank;
  logic [MAG_WIDTH-1:0]    r_rd_data;
  logic [MAG_WIDTH-1:0]    r_ram [2*N_BINS];

  assign w_in_tag = '{valid: i_axi4s_data.tvalid,
                      last:  i_axi4s_data.tlast,
                      idx:   i_axi4s_data.tuser[LOGS_FFT_LEN-1:0]};
  assign w_unused_tuser = ^i_axi4s_data.tuser[TUSER_WIDTH-1:LOGS_FFT_LEN];

  fft_mag_approx u_approx (
    .i_clk    (i_clk),
    .srstn    (srstn),
    .i_aclken (i_aclken),
    .i_tdata  (i_axi4s_data.tdata),
    .i_tag    (w_in_tag),
    .o_mag_c  (w_mag),
    .o_tag_c  (w_tag)
  );

  always_ff @(posedge i_clk or negedge srstn) begin
    if (!srstn) r_state <= ST_ACCUM;
    else if (i_aclken) r_state <= w_state_nxt;
  end

  // Frame accounting on each sample leaving the pipeline; ST_DISCARD skips to the next tlast
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_swap      = 1'b0;
    w_drop      = 1'b0;
    w_err       = 1'b0;
    if (w_tag.valid) begin
      if (r_state == ST_ACCUM) begin
        w_wr_en = 1'b1;
        if (w_tag.last) begin
          w_cnt_nxt = '0;
          if (r_cnt != CNT_LAST) w_err  = 1'b1;
          else if (i_rd_busy)    w_drop = 1'b1;
          else                   w_swap = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_err       = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DISCARD;
        end else begin
          w_cnt_nxt = r_cnt + LOGS_FFT_LEN'(1);
        end
      end else if (w_tag.last) begin
        w_state_nxt = ST_ACCUM;
      end
    end
  end

  // The read bank follows o_rd_bank one enabled cycle late so reads issued during
  // the o_frame_done cycle still see the previous frame
  always_ff @(posedge i_clk or negedge srstn) begin
    if (!srstn) begin
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
      r_err      <= 1'b0;
      r_pub_bank <= 1'b0;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b1;
      r_rd_data  <= '0;
    end else if (i_aclken) begin
      r_cnt     <= w_cnt_nxt;
      r_done    <= w_swap;
      r_drop    <= w_drop;
      r_err     <= w_err;
      r_rd_data <= r_ram[{r_rd_bank, i_rd_addr}];
      if (w_swap) begin
        r_pub_bank <= ~r_pub_bank;
        r_wr_bank  <= ~r_wr_bank;
      end
      if (r_done) r_rd_bank <= ~r_rd_bank;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_aclken && w_wr_en) r_ram[{r_wr_bank, w_tag.idx}] <= w_mag;
  end

  assign o_rd_data    = r_rd_data;
  assign o_frame_done = r_done;
  assign o_frame_drop = r_drop;
  assign o_len_err    = r_err;
  assign o_rd_bank    = r_pub_bank;

`ifdef FFT_MAG_PEAK_EN
  logic [MAG_WIDTH-1:0]    r_trk_mag;
  logic [LOGS_FFT_LEN-1:0] r_trk_idx;
  logic [MAG_WIDTH-1:0]    w_trk_mag;
  logic [LOGS_FFT_LEN-1:0] w_trk_idx;
  logic [MAG_WIDTH-1:0]    r_peak_mag;
  logic [LOGS_FFT_LEN-1:0] r_peak_idx;

  // First sample of a frame seeds the tracker; strict > keeps the earliest of equal peaks
  always_comb begin
    w_trk_mag = r_trk_mag;
    w_trk_idx = r_trk_idx;
    if ((r_cnt == '0) || (w_mag > r_trk_mag)) begin
      w_trk_mag = w_mag;
      w_trk_idx = w_tag.idx;
    end
  end

  always_ff @(posedge i_clk or negedge srstn) begin
    if (!srstn) begin
      r_trk_mag  <= '0;
      r_trk_idx  <= '0;
      r_peak_mag <= '0;
      r_peak_idx <= '0;
    end else if (i_aclken) begin
      if (w_wr_en) begin
        r_trk_mag <= w_trk_mag;
        r_trk_idx <= w_trk_idx;
      end
      if (w_swap) begin
        r_peak_mag <= w_trk_mag;
        r_peak_idx <= w_trk_idx;
      end
    end
  end

  assign o_peak_mag = r_peak_mag;
  assign o_peak_idx = r_peak_idx;
`endif

endmodule

// File: tb/tb_fft_mag_frame_buf.sv
// Randomized frame stimulus checked against a behavioural magnitude / frame model.
module tb_fft_mag_frame_buf;
  import fft_mag_pkg::*;

  localparam int NB = N_BINS;

  logic                    i_clk = 1'b0;
  logic                    srstn = 1'b0;
  logic                    i_aclken = 1'b1;
  logic                    i_rd_busy = 1'b0;
  logic [LOGS_FFT_LEN-1:0] i_rd_addr = '0;
  logic [MAG_WIDTH-1:0]    o_rd_data;
  logic                    o_frame_done;
  logic                    o_frame_drop;
  logic                    o_len_err;
  logic                    o_rd_bank;
`ifdef FFT_MAG_PEAK_EN
  logic [LOGS_FFT_LEN-1:0] o_peak_idx;
  logic [MAG_WIDTH-1:0]    o_peak_mag;
`endif

  fft_mag_frame_buf_if axis ();

  fft_mag_frame_buf dut (
    .i_clk        (i_clk),
    .srstn        (srstn),
    .i_aclken     (i_aclken),
    .i_axi4s_data (axis),
    .i_rd_busy    (i_rd_busy),
    .i_rd_addr    (i_rd_addr),
    .o_rd_data    (o_rd_data),
    .o_frame_done (o_frame_done),
    .o_frame_drop (o_frame_drop),
    .o_len_err    (o_len_err),
    .o_rd_bank    (o_rd_bank)
`ifdef FFT_MAG_PEAK_EN
    ,
    .o_peak_idx   (o_peak_idx),
    .o_peak_mag   (o_peak_mag)
`endif
  );

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_drop = 0;
  int n_err  = 0;
  int cyc    = 0;
  bit en_toggle = 1'b0;
  bit exp_bank  = 1'b0;
  int sb        = 0;
  int first_bad = 0;

  logic signed [DATA_WIDTH-1:0] re_a [NB];
  logic signed [DATA_WIDTH-1:0] im_a [NB];
  int pub [NB];
  int rb  [NB];

  always #5 i_clk = ~i_clk;

  // Clock enable changes just after each rising edge: always-on, or 1 of 3 cycles
  always @(posedge i_clk) begin
    #1;
    cyc = cyc + 1;
    i_aclken = en_toggle ? (cyc % 3 == 0) : 1'b1;
  end

  // Pulses are counted once per enabled cycle they are high
  always @(negedge i_clk) begin
    if (srstn && i_aclken) begin
      if (o_frame_done) n_done = n_done + 1;
      if (o_frame_drop) n_drop = n_drop + 1;
      if (o_len_err)    n_err  = n_err + 1;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic longint abs_ref(input logic signed [DATA_WIDTH-1:0] x);
    longint a;
    longint lim;
    lim = (longint'(1) << (DATA_WIDTH - 1)) - 1;
    a = longint'(x);
    if (a < 0) a = -a;
    if (a > lim) a = lim;
    return a;
  endfunction

  function automatic int ref_mag(input logic signed [DATA_WIDTH-1:0] re,
                                 input logic signed [DATA_WIDTH-1:0] im);
    longint a, b, mx, mn, m;
    a = abs_ref(re);
    b = abs_ref(im);
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    m = mx + mn / 4 + mn / 8;
    m = m >> MAG_SHIFT;
    if (m > longint'(MAG_MAX)) m = longint'(MAG_MAX);
    return int'(m);
  endfunction

  function automatic int count_diff();
    int bad;
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < NB; i++) begin
      if (rb[i] != pub[i]) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    end
    return bad;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic fill_zero();
    for (int i = 0; i < NB; i++) begin
      re_a[i] = '0;
      im_a[i] = '0;
    end
  endtask

  task automatic fill_random();
    logic signed [DATA_WIDTH-1:0] t;
    for (int i = 0; i < NB; i++) begin
      t = DATA_WIDTH'($urandom);
      re_a[i] = t >>> $urandom_range(4, DATA_WIDTH - 1);
      t = DATA_WIDTH'($urandom);
      im_a[i] = t >>> $urandom_range(4, DATA_WIDTH - 1);
    end
  endtask

  // One sample held until an enabled edge accepts it; lane pad and tuser high bits are junk
  task automatic put(input int k, input bit last);
    axis.tvalid = 1'b1;
    axis.tdata  = {4'($urandom), im_a[k], 4'($urandom), re_a[k]};
    axis.tuser  = {5'($urandom), 11'(k)};
    axis.tlast  = last;
    @(posedge i_clk);
    while (!i_aclken) @(posedge i_clk);
    #1;
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input int last_at);
    for (int k = from; k <= to; k++) put(k % NB, k == last_at);
  endtask

  task automatic publish_model();
    for (int i = 0; i < NB; i++) pub[i] = ref_mag(re_a[i], im_a[i]);
    exp_bank = ~exp_bank;
  endtask

  task automatic read_all();
    for (int a = 0; a < NB; a++) begin
      i_rd_addr = LOGS_FFT_LEN'(a);
      @(posedge i_clk);
      #1;
      rb[a] = int'(o_rd_data);
    end
  endtask

  task automatic test_reset();
    srstn = 1'b0;
    wait_clk(3);
    checks++; if (o_rd_data !== '0)  begin errors++; $display("FAIL reset_rd_data got %0d exp 0", o_rd_data); end
    checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", o_frame_done); end
    checks++; if (o_frame_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", o_frame_drop); end
    checks++; if (o_len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err got %b exp 0", o_len_err); end
    checks++; if (o_rd_bank !== 1'b0) begin errors++; $display("FAIL reset_rd_bank got %b exp 0", o_rd_bank); end
`ifdef FFT_MAG_PEAK_EN
    checks++; if (o_peak_mag !== '0 || o_peak_idx !== '0) begin errors++; $display("FAIL reset_peak got %0d/%0d exp 0/0", o_peak_mag, o_peak_idx); end
`endif
    srstn = 1'b1;
    exp_bank = 1'b0;
    wait_clk(2);
  endtask

  task automatic test_single_bin();
    int d0, e0;
    d0 = n_done; e0 = n_err;
    fill_zero();
    re_a[sb] = 28'sd3000;
    im_a[sb] = -28'sd4000;
    send_range(0, NB - 1, NB - 1);
    wait_clk(8);
    publish_model();
    checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL single_done_count got %0d exp 1", n_done - d0); end
    checks++; if (n_err != e0) begin errors++; $display("FAIL single_len_err got %0d exp 0", n_err - e0); end
    checks++; if (o_rd_bank !== exp_bank) begin errors++; $display("FAIL single_rd_bank got %b exp %b", o_rd_bank, exp_bank); end
    read_all();
    checks++; if (rb[sb] != 5125) begin errors++; $display("FAIL single_bin got %0d exp 5125", rb[sb]); end
    checks++; if (rb[(sb + 1) % NB] != 0) begin errors++; $display("FAIL single_other got %0d exp 0", rb[(sb + 1) % NB]); end
    checks++; if (count_diff() != 0) begin errors++; $display("FAIL single_readback bin %0d got %0d exp %0d", first_bad, rb[first_bad], pub[first_bad]); end
`ifdef FFT_MAG_PEAK_EN
    checks++; if (o_peak_mag !== 16'd5125 || o_peak_idx !== 11'(sb)) begin errors++; $display("FAIL single_peak got %0d@%0d exp 5125@%0d", o_peak_mag, o_peak_idx, sb); end
`endif
  endtask

  task automatic test_saturation();
    int d0;
    d0 = n_done;
    fill_random();
    re_a[5] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    im_a[5] = '0;
    re_a[9] = 28'sd100;
    im_a[9] = 28'sd100;
    send_range(0, NB - 1, NB - 1);
    wait_clk(8);
    publish_model();
    checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL sat_done_count got %0d exp 1", n_done - d0); end
    checks++; if (o_rd_bank !== exp_bank) begin errors++; $display("FAIL sat_rd_bank got %b exp %b", o_rd_bank, exp_bank); end
    read_all();
    checks++; if (rb[5] != 65535) begin errors++; $display("FAIL sat_min_neg got %0d exp 65535", rb[5]); end
    checks++; if (rb[9] != 137) begin errors++; $display("FAIL sat_100_100 got %0d exp 137", rb[9]); end
    checks++; if (count_diff() != 0) begin errors++; $display("FAIL sat_readback bin %0d got %0d exp %0d", first_bad, rb[first_bad], pub[first_bad]); end
  endtask

  task automatic test_drop();
    int d0, p0;
    d0 = n_done; p0 = n_drop;
    fill_random();
    i_rd_busy = 1'b1;
    send_range(0, NB - 1, NB - 1);
    wait_clk(8);
    checks++; if (n_drop - p0 != 1) begin errors++; $display("FAIL drop_count got %0d exp 1", n_drop - p0); end
    checks++; if (n_done != d0) begin errors++; $display("FAIL drop_done got %0d exp 0", n_done - d0); end
    checks++; if (o_rd_bank !== exp_bank) begin errors++; $display("FAIL drop_rd_bank got %b exp %b", o_rd_bank, exp_bank); end
    read_all();
    checks++; if (count_diff() != 0) begin errors++; $display("FAIL drop_old_data bin %0d got %0d exp %0d", first_bad, rb[first_bad], pub[first_bad]); end
    i_rd_busy = 1'b0;
    fill_random();
    send_range(0, NB - 1, NB - 1);
    wait_clk(8);
    publish_model();
    checks++; if (n_done - d0 != 1 || n_drop - p0 != 1) begin errors++; $display("FAIL drop_recover done %0d drop %0d exp 1 1", n_done - d0, n_drop - p0); end
    read_all();
    checks++; if (count_diff() != 0) begin errors++; $display("FAIL drop_recover_readback bin %0d got %0d exp %0d", first_bad, rb[first_bad], pub[first_bad]); end
  endtask

  task automatic test_short_frame();
    int d0, e0;
    d0 = n_done; e0 = n_err;
    fill_random();
    send_range(0, 1000, 1000);
    wait_clk(8);
    checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL short_len_err got %0d exp 1", n_err - e0); end
    checks++; if (n_done != d0 || o_rd_bank !== exp_bank) begin errors++; $display("FAIL short_no_swap done %0d bank %b exp 0 %b", n_done - d0, o_rd_bank, exp_bank); end
    read_all();
    checks++; if (count_diff() != 0) begin errors++; $display("FAIL short_old_data bin %0d got %0d exp %0d", first_bad, rb[first_bad], pub[first_bad]); end
    fill_random();
    send_range(0, NB - 1, NB - 1);
    wait_clk(8);
    publish_model();
    checks++; if (n_done - d0 != 1 || n_err - e0 != 1) begin errors++; $display("FAIL short_recover done %0d err %0d exp 1 1", n_done - d0, n_err - e0); end
    read_all();
    checks++; if (count_diff() != 0) begin errors++; $display("FAIL short_recover_readback bin %0d got %0d exp %0d", first_bad, rb[first_bad], pub[first_bad]); end
  endtask

  task automatic test_no_tlast();
    int d0, e0;
    d0 = n_done; e0 = n_err;
    fill_random();
    send_range(0, NB + 5, NB + 5);
    wait_clk(8);
    checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL notlast_len_err got %0d exp 1", n_err - e0); end
    checks++; if (n_done != d0) begin errors++; $display("FAIL notlast_done got %0d exp 0", n_done - d0); end
    fill_random();
    send_range(0, NB - 1, NB - 1);
    wait_clk(8);
    publish_model();
    checks++; if (n_done - d0 != 1 || n_err - e0 != 1) begin errors++; $display("FAIL notlast_recover done %0d err %0d exp 1 1", n_done - d0, n_err - e0); end
    checks++; if (o_rd_bank !== exp_bank) begin errors++; $display("FAIL notlast_rd_bank got %b exp %b", o_rd_bank, exp_bank); end
    read_all();
    checks++; if (count_diff() != 0) begin errors++; $display("FAIL notlast_readback bin %0d got %0d exp %0d", first_bad, rb[first_bad], pub[first_bad]); end
  endtask

  task automatic test_aclken();
    int d0;
    d0 = n_done;
    fill_zero();
    re_a[sb] = 28'sd3000;
    im_a[sb] = -28'sd4000;
    en_toggle = 1'b1;
    send_range(0, NB - 1, NB - 1);
    wait_clk(40);
    en_toggle = 1'b0;
    wait_clk(4);
    publish_model();
    checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL aclken_done_enabled_cycles got %0d exp 1", n_done - d0); end
    checks++; if (o_rd_bank !== exp_bank) begin errors++; $display("FAIL aclken_rd_bank got %b exp %b", o_rd_bank, exp_bank); end
    read_all();
    checks++; if (count_diff() != 0) begin errors++; $display("FAIL aclken_readback bin %0d got %0d exp %0d", first_bad, rb[first_bad], pub[first_bad]); end
`ifdef FFT_MAG_PEAK_EN
    checks++; if (o_peak_mag !== 16'd5125 || o_peak_idx !== 11'(sb)) begin errors++; $display("FAIL aclken_peak got %0d@%0d exp 5125@%0d", o_peak_mag, o_peak_idx, sb); end
`endif
  endtask

  task automatic test_reset_midframe();
    int d0, e0;
    fill_random();
    send_range(0, 499, -1);
    srstn = 1'b0;
    wait_clk(2);
    srstn = 1'b1;
    exp_bank = 1'b0;
    wait_clk(1);
    checks++; if (o_rd_bank !== 1'b0 || o_frame_done !== 1'b0) begin errors++; $display("FAIL midreset_outputs bank %b done %b exp 0 0", o_rd_bank, o_frame_done); end
    d0 = n_done; e0 = n_err;
    send_range(500, NB - 1, NB - 1);
    wait_clk(8);
    checks++; if (n_err - e0 != 1 || n_done != d0) begin errors++; $display("FAIL midreset_short err %0d done %0d exp 1 0", n_err - e0, n_done - d0); end
    fill_random();
    send_range(0, NB - 1, NB - 1);
    wait_clk(8);
    publish_model();
    checks++; if (n_done - d0 != 1 || o_rd_bank !== exp_bank) begin errors++; $display("FAIL midreset_recover done %0d bank %b exp 1 %b", n_done - d0, o_rd_bank, exp_bank); end
    read_all();
    checks++; if (count_diff() != 0) begin errors++; $display("FAIL midreset_readback bin %0d got %0d exp %0d", first_bad, rb[first_bad], pub[first_bad]); end
  endtask

  initial begin
    axis.tvalid = 1'b0;
    axis.tdata  = '0;
    axis.tlast  = 1'b0;
    axis.tuser  = '0;
    sb = int'($urandom_range(0, NB - 1));
    test_reset();
    test_single_bin();
    test_saturation();
    test_drop();
    test_short_frame();
    test_no_tlast();
    test_aclken();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
